// File: rtl/bfloat16_rf_mul_seq.sv
// Sequencer that reads two bfloat16 operands from the register file, multiplies them and writes the product back.
// Define BF16_MUL_RNE_EN for round-to-nearest-even; the default build truncates.
module bfloat16_rf_mul_seq #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_a,
    input  logic [ADDR_WIDTH-1:0] src_b,
    input  logic [ADDR_WIDTH-1:0] dst,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_di,
    input  logic [DATA_WIDTH-1:0] rf_dout
);

`ifdef BF16_MUL_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, MUL, WR, DONE} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   src_b_q, dst_q;
    logic [DATA_WIDTH-1:0]   a_reg, b_reg;
    logic [15:0]             product;

    logic                    sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]              exp_a, exp_b;
    logic [6:0]              man_a, man_b, frac, frac_r;
    logic [15:0]             sig_p;
    logic signed [9:0]       exp_s, exp_n, exp_r;
    logic                    guard, sticky, inc, carry;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD_A;
            RD_A:    state_next = RD_B;
            RD_B:    state_next = CAP_B;
            CAP_B:   state_next = MUL;
            MUL:     state_next = WR;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign rf_di = result;

    // rf_addr/rf_we are set one state early so they are registered outputs when the state is entered.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rf_addr <= src_a;
                    src_b_q <= src_b;
                    dst_q   <= dst;
                end
                RD_A:  rf_addr <= src_b_q;
                RD_B:  a_reg   <= rf_dout;
                CAP_B: b_reg   <= rf_dout;
                MUL: begin
                    result  <= product;
                    rf_we   <= 1'b1;
                    rf_addr <= dst_q;
                end
                WR:      rf_we <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        sign   = a_reg[15] ^ b_reg[15];
        exp_a  = a_reg[14:7];
        exp_b  = b_reg[14:7];
        man_a  = a_reg[6:0];
        man_b  = b_reg[6:0];
        a_nan  = (exp_a == 8'hFF) && (man_a != 7'd0);
        b_nan  = (exp_b == 8'hFF) && (man_b != 7'd0);
        a_inf  = (exp_a == 8'hFF) && (man_a == 7'd0);
        b_inf  = (exp_b == 8'hFF) && (man_b == 7'd0);
        a_zero = (exp_a == 8'h00);
        b_zero = (exp_b == 8'h00);

        sig_p  = {8'd0, 1'b1, man_a} * {8'd0, 1'b1, man_b};
        exp_s  = $signed({2'b00, exp_a} + {2'b00, exp_b} - 10'd127);
        if (sig_p[15]) begin
            frac   = sig_p[14:8];
            exp_n  = exp_s + 10'sd1;
            guard  = sig_p[7];
            sticky = |sig_p[6:0];
        end else begin
            frac   = sig_p[13:7];
            exp_n  = exp_s;
            guard  = sig_p[6];
            sticky = |sig_p[5:0];
        end
        inc             = RNE & guard & (sticky | frac[0]);
        {carry, frac_r} = {1'b0, frac} + {7'd0, inc};
        exp_r           = carry ? exp_n + 10'sd1 : exp_n;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            product = 16'h7FC0;
        else if (a_inf || b_inf)
            product = {sign, 8'hFF, 7'd0};
        else if (a_zero || b_zero)
            product = {sign, 15'd0};
        else if (exp_r >= 10'sd255)
            product = {sign, 8'hFF, 7'd0};
        else if (exp_r <= 10'sd0)
            product = {sign, 15'd0};
        else
            product = {sign, exp_r[7:0], frac_r};
    end

endmodule
